// File: rtl/state_sequencer_pkg.sv
// Shared codes for the instruction-cycle sequencer: state encoding and helpers.
package state_sequencer_pkg;

    // FETCH/EXEC1/EXEC2 keep their historical codes; HALT takes the spare one.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic logic is_active(state_t s);
        return s != HALT;
    endfunction

endpackage

// File: rtl/state_sequencer_if.sv
// Bundles the memory/execution-unit status inputs and the sequencer status outputs.
interface state_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    import state_sequencer_pkg::*;

    // Handshake: waitrequest_i is the inverted ready of the memory side; a state
    // advances only on a cycle with waitrequest_i=0 (and stall_i=0 in EXEC1/EXEC2).
    logic                   waitrequest_i;
    logic                   stall_i;
    logic                   halt_i;
    state_t                 state_o;
    logic                   state_entry_o;
    logic                   active_o;
    logic                   fault_o;
    logic [COUNT_WIDTH-1:0] instr_count_o;
    logic [COUNT_WIDTH-1:0] cycle_count_o;

    modport master (
        output waitrequest_i, stall_i, halt_i,
        input  state_o, state_entry_o, active_o, fault_o, instr_count_o, cycle_count_o
    );

    modport slave (
        input  waitrequest_i, stall_i, halt_i,
        output state_o, state_entry_o, active_o, fault_o, instr_count_o, cycle_count_o
    );

endinterface

// File: rtl/state_sequencer_wait_watchdog.sv
// Counts consecutive waitrequest cycles and flags expiry when the limit is reached.
module wait_watchdog #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q, count_d;

    // A limit of zero disables the watchdog entirely.
    assign expired_o = (WAIT_LIMIT != 0) && count_en_i && (count_q == LIMIT_V);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LIMIT_V)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/state_sequencer.sv
// FETCH/EXEC1/EXEC2 instruction sequencer with halt, wait watchdog and perf counters.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int WAIT_LIMIT  = 1023
) (
    input  logic              clk,
    input  logic              reset,
    state_sequencer_if.slave  bus
);
    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   entry_q;
    logic                   active_q;
    logic                   fault_q;
    logic [COUNT_WIDTH-1:0] instr_q;
    logic [COUNT_WIDTH-1:0] cycle_q;
    logic                   retire;
    logic                   wd_expired;
    logic                   wd_count_en;

    assign wd_count_en = bus.waitrequest_i && is_active(state_q);

    wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_watchdog (
        .clk        (clk),
        .reset      (reset),
        .count_en_i (wd_count_en),
        .clear_i    (!bus.waitrequest_i),
        .expired_o  (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            FETCH: if (!bus.waitrequest_i) state_d = EXEC1;
            EXEC1: if (!bus.waitrequest_i && !bus.stall_i) state_d = EXEC2;
            EXEC2: begin
                if (!bus.waitrequest_i && !bus.stall_i) begin
                    retire  = 1'b1;
                    state_d = bus.halt_i ? HALT : FETCH;
                end
            end
            HALT: state_d = HALT;
        endcase
        // Expiry only happens with waitrequest_i high, so it never overlaps a retire.
        if (wd_expired) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            entry_q  <= 1'b1;
            active_q <= 1'b1;
            fault_q  <= 1'b0;
            instr_q  <= '0;
            cycle_q  <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= (state_d != state_q);
            active_q <= is_active(state_d);
            if (wd_expired) fault_q <= 1'b1;
            if (retire) instr_q <= instr_q + ONE;
            if (is_active(state_q)) cycle_q <= cycle_q + ONE;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.state_entry_o = entry_q;
    assign bus.active_o      = active_q;
    assign bus.fault_o       = fault_q;
    assign bus.instr_count_o = instr_q;
    assign bus.cycle_count_o = cycle_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Checks the sequencer against a per-instruction reference model plus directed corner cases.
module tb_state_sequencer;
  import state_sequencer_pkg::*;

  localparam int CW = 4;
  localparam int WL = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  state_sequencer_if #(.COUNT_WIDTH(CW)) bus ();

  state_sequencer #(
    .COUNT_WIDTH (CW),
    .WAIT_LIMIT  (WL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: position within the 3-step instruction, halted flag,
  // run length of consecutive waits, and unbounded counts reduced mod 2^CW.
  int m_phase;
  bit m_halted;
  bit m_entry;
  bit m_fault;
  int m_wait_run;
  int m_instr;
  int m_cycle;

  typedef struct {
    logic w, s, h;
    state_t st;
    logic entry;
    int instr;
    int cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic state_t m_state();
    if (m_halted) return HALT;
    case (m_phase)
      0: return FETCH;
      1: return EXEC1;
      default: return EXEC2;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_halted = 0; m_entry = 1; m_fault = 0;
    m_wait_run = 0; m_instr = 0; m_cycle = 0;
  endtask

  task automatic model_step(input logic w, input logic s, input logic h);
    m_entry = 0;
    if (m_halted) return;
    m_cycle++;
    if (w) begin
      if (m_wait_run == WL) begin
        m_halted = 1; m_fault = 1; m_entry = 1;
      end else begin
        m_wait_run++;
      end
    end else begin
      m_wait_run = 0;
      if (m_phase == 0 || !s) begin
        m_entry = 1;
        if (m_phase == 2) begin
          m_instr++;
          if (h) m_halted = 1;
          else m_phase = 0;
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(bus.state_o), 32'(m_state()));
    chk({tag, ".entry"}, 32'(bus.state_entry_o), 32'(m_entry));
    chk({tag, ".active"}, 32'(bus.active_o), 32'(!m_halted));
    chk({tag, ".fault"}, 32'(bus.fault_o), 32'(m_fault));
    chk({tag, ".instr"}, 32'(bus.instr_count_o), 32'(m_instr % (1 << CW)));
    chk({tag, ".cycle"}, 32'(bus.cycle_count_o), 32'(m_cycle % (1 << CW)));
  endtask

  task automatic cycle(input string tag, input logic w, input logic s, input logic h);
    bus.waitrequest_i = w;
    bus.stall_i = s;
    bus.halt_i = h;
    model_step(w, s, h);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic w);
    bus.waitrequest_i = w;
    bus.stall_i = 1'($urandom_range(0, 1));
    bus.halt_i = 1'($urandom_range(0, 1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int burst;
    int halt_wait;
    int frozen;
    bus.waitrequest_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.halt_i = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, EXEC1, 1'b1, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, EXEC1, 1'b0, 0, 2};
    vecs[2] = '{1'b0, 1'b0, 1'b1, EXEC2, 1'b1, 0, 3};
    vecs[3] = '{1'b0, 1'b0, 1'b0, FETCH, 1'b1, 1, 4};
    vecs[4] = '{1'b0, 1'b1, 1'b1, EXEC1, 1'b1, 1, 5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, EXEC1, 1'b0, 1, 6};
    vecs[6] = '{1'b0, 1'b0, 1'b0, EXEC2, 1'b1, 1, 7};
    vecs[7] = '{1'b1, 1'b0, 1'b1, EXEC2, 1'b0, 1, 8};
    vecs[8] = '{1'b0, 1'b0, 1'b0, FETCH, 1'b1, 2, 9};

    repeat (2) @(posedge clk);
    #1;
    do_reset("reset", 1'b0);

    // Table of single-cycle vectors.
    for (int i = 0; i < 9; i++) begin
      cycle("vec", vecs[i].w, vecs[i].s, vecs[i].h);
      chk($sformatf("vec%0d.state", i), 32'(bus.state_o), 32'(vecs[i].st));
      chk($sformatf("vec%0d.entry", i), 32'(bus.state_entry_o), 32'(vecs[i].entry));
      chk($sformatf("vec%0d.instr", i), 32'(bus.instr_count_o), 32'(vecs[i].instr));
      chk($sformatf("vec%0d.cycle", i), 32'(bus.cycle_count_o), 32'(vecs[i].cyc));
    end

    // Three back-to-back instructions with no waits.
    do_reset("seq3.reset", 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cycle("seq3", 1'b0, 1'b0, 1'b0);
      chk("seq3.order", 32'(bus.state_o),
          (k % 3 == 1) ? 32'(EXEC1) : (k % 3 == 2) ? 32'(EXEC2) : 32'(FETCH));
    end
    chk("seq3.instr_final", 32'(bus.instr_count_o), 32'd3);
    chk("seq3.cycle_final", 32'(bus.cycle_count_o), 32'd9);

    // Waits in FETCH hold the state while cycles keep counting.
    do_reset("fwait.reset", 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle("fwait", 1'b1, 1'b1, 1'b0);
      chk("fwait.hold", 32'(bus.state_o), 32'(FETCH));
      chk("fwait.entry_low", 32'(bus.state_entry_o), 32'd0);
    end
    chk("fwait.cycles", 32'(bus.cycle_count_o), 32'd4);
    cycle("fwait.release", 1'b0, 1'b0, 1'b0);
    chk("fwait.exec1", 32'(bus.state_o), 32'(EXEC1));

    // Stall held in EXEC2, then retire.
    do_reset("stall.reset", 1'b0);
    cycle("stall", 1'b0, 1'b0, 1'b0);
    cycle("stall", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle("stall.hold", 1'b0, 1'b1, 1'b1);
      chk("stall.exec2", 32'(bus.state_o), 32'(EXEC2));
      chk("stall.instr0", 32'(bus.instr_count_o), 32'd0);
    end
    cycle("stall.release", 1'b0, 1'b0, 1'b0);
    chk("stall.fetch", 32'(bus.state_o), 32'(FETCH));
    chk("stall.instr1", 32'(bus.instr_count_o), 32'd1);

    // Halt on retire, counters frozen, reset recovers.
    cycle("halt", 1'b0, 1'b0, 1'b0);
    cycle("halt", 1'b0, 1'b0, 1'b0);
    cycle("halt.retire", 1'b0, 1'b0, 1'b1);
    chk("halt.state", 32'(bus.state_o), 32'(HALT));
    chk("halt.active", 32'(bus.active_o), 32'd0);
    chk("halt.instr", 32'(bus.instr_count_o), 32'd2);
    frozen = int'(bus.cycle_count_o);
    for (int k = 0; k < 20; k++) begin
      cycle("halt.frozen", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("halt.cycle_frozen", 32'(bus.cycle_count_o), 32'(frozen));
    chk("halt.instr_frozen", 32'(bus.instr_count_o), 32'd2);
    do_reset("halt.reset", 1'b0);
    chk("halt.reset_state", 32'(bus.state_o), 32'(FETCH));

    // Reset mid-wait clears the watchdog; then a full wait run faults from FETCH.
    cycle("midwait", 1'b1, 1'b0, 1'b0);
    cycle("midwait", 1'b1, 1'b0, 1'b0);
    cycle("midwait", 1'b1, 1'b0, 1'b0);
    do_reset("midwait.reset", 1'b1);
    for (int k = 0; k < 8; k++) cycle("fwd", 1'b1, 1'b0, 1'b0);
    chk("fwd.still_fetch", 32'(bus.state_o), 32'(FETCH));
    cycle("fwd.expire", 1'b1, 1'b0, 1'b0);
    chk("fwd.halt", 32'(bus.state_o), 32'(HALT));
    chk("fwd.fault", 32'(bus.fault_o), 32'd1);

    // Watchdog expiry in EXEC1.
    do_reset("ewd.reset", 1'b0);
    cycle("ewd", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle("ewd.wait", 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      chk("ewd.exec1", 32'(bus.state_o), 32'(EXEC1));
    end
    cycle("ewd.expire", 1'b1, 1'b0, 1'b0);
    chk("ewd.halt", 32'(bus.state_o), 32'(HALT));
    chk("ewd.fault", 32'(bus.fault_o), 32'd1);
    chk("ewd.instr", 32'(bus.instr_count_o), 32'd0);

    // Counter wrap at 16 retires.
    do_reset("wrap.reset", 1'b0);
    for (int k = 0; k < 48; k++) cycle("wrap", 1'b0, 1'b0, 1'b0);
    chk("wrap.instr", 32'(bus.instr_count_o), 32'd0);
    chk("wrap.cycle", 32'(bus.cycle_count_o), 32'd0);

    // Random traffic against the model, with bursts long enough to hit the watchdog.
    do_reset("rnd.reset", 1'b0);
    burst = 0;
    halt_wait = 0;
    for (int n = 0; n < 800; n++) begin
      logic w;
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(5, 12);
      if (burst > 0) begin
        w = 1'b1;
        burst--;
      end else begin
        w = ($urandom_range(0, 4) == 0);
      end
      cycle("rnd", w, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      if (m_halted) halt_wait++;
      if (halt_wait > 3) begin
        halt_wait = 0;
        burst = 0;
        do_reset("rnd.reset", 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
